// File: rtl/z16_dmem_arbiter.sv
// z16_dmem_arbiter
// Shares the single Z16 data-memory/MMIO port between the CPU load/store path
// and a debug/loader master. One access is granted per cycle. Grants are
// combinational from the registered priority state and the current requests,
// so an access completes in the cycle it is requested.
//
// The CPU is stalled while the debug master owns the port. A locked debug
// burst keeps debug priority across cycles. A wait counter bounds how long a
// requesting CPU can be denied: once it reaches MAX_WAIT, the CPU gets the
// port in any state.
module z16_dmem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // CPU load/store port
  input  logic          i_cpu_req,
  input  logic          i_cpu_wen,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_gnt,
  output logic          o_cpu_stall,
  output logic [DW-1:0] o_cpu_rdata,
  // Debug / loader port
  input  logic          i_dbg_req,
  input  logic          i_dbg_wen,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  input  logic          i_dbg_lock,
  output logic          o_dbg_gnt,
  output logic [DW-1:0] o_dbg_rdata,
  // Shared memory / MMIO port
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_wen,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  // Debug visibility
  output logic [1:0]    o_state
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_CPU_PRI  = 2'd0,  // CPU wins contention
    S_DBG_PRI  = 2'd1,  // debug wins contention
    S_DBG_LOCK = 2'd2   // debug burst in progress
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;

  logic forced;
  logic cpu_gnt;
  logic dbg_gnt;

  // Register priority state and the CPU starvation counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_CPU_PRI;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Decide who owns the port this cycle. A starved CPU overrides all states,
  // and nobody is granted while reset is held so no write can slip through.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    forced  = i_cpu_req && (wait_q == WAIT_MAX);
    if (!i_rst) begin
      if (forced) begin
        cpu_gnt = 1'b1;
      end else begin
        case (state_q)
          S_CPU_PRI: begin
            if (i_cpu_req)      cpu_gnt = 1'b1;
            else if (i_dbg_req) dbg_gnt = 1'b1;
          end
          default: begin
            // S_DBG_PRI and S_DBG_LOCK both favour debug; the lock state only
            // differs in how it persists across cycles.
            if (i_dbg_req)      dbg_gnt = 1'b1;
            else if (i_cpu_req) cpu_gnt = 1'b1;
          end
        endcase
      end
    end
  end

  // Next priority state and starvation count from this cycle's outcome.
  always_comb begin
    state_d = S_CPU_PRI;
    if (dbg_gnt) begin
      state_d = i_dbg_lock ? S_DBG_LOCK : S_CPU_PRI;
    end else if (cpu_gnt) begin
      // A forced CPU slot inside a burst does not break the lock.
      if (forced && (state_q == S_DBG_LOCK) && i_dbg_lock) state_d = S_DBG_LOCK;
      else if (i_dbg_req)                                  state_d = S_DBG_PRI;
      else                                                 state_d = S_CPU_PRI;
    end else begin
      // Lock survives idle gaps as long as the debug master keeps it raised.
      if ((state_q == S_DBG_LOCK) && i_dbg_lock) state_d = S_DBG_LOCK;
    end

    wait_d = '0;
    if (i_cpu_req && !cpu_gnt) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WCW'(1);
    end
  end

  // Steer the granted master onto the memory port; idle port is all zeros.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    if (cpu_gnt) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wen   = i_cpu_wen;
      o_mem_wdata = i_cpu_wdata;
    end else if (dbg_gnt) begin
      o_mem_addr  = i_dbg_addr;
      o_mem_wen   = i_dbg_wen;
      o_mem_wdata = i_dbg_wdata;
    end
  end

  assign o_cpu_gnt   = cpu_gnt;
  assign o_dbg_gnt   = dbg_gnt;
  assign o_cpu_stall = i_cpu_req && !cpu_gnt;
  assign o_cpu_rdata = i_mem_rdata;
  assign o_dbg_rdata = i_mem_rdata;
  assign o_state     = state_q;

endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// Testbench for z16_dmem_arbiter: directed scenarios with literal expectations
// followed by random two-master traffic, all checked every cycle against a
// behavioural arbitration/memory model.
module tb_z16_dmem_arbiter;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cpu_req, i_cpu_wen;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic          o_cpu_gnt, o_cpu_stall;
  logic [DW-1:0] o_cpu_rdata;
  logic          i_dbg_req, i_dbg_wen, i_dbg_lock;
  logic [AW-1:0] i_dbg_addr;
  logic [DW-1:0] i_dbg_wdata;
  logic          o_dbg_gnt;
  logic [DW-1:0] o_dbg_rdata;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_wen;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic [1:0]    o_state;

  logic          init_mem;
  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  z16_dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cpu_req  (i_cpu_req),
    .i_cpu_wen  (i_cpu_wen),
    .i_cpu_addr (i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_gnt  (o_cpu_gnt),
    .o_cpu_stall(o_cpu_stall),
    .o_cpu_rdata(o_cpu_rdata),
    .i_dbg_req  (i_dbg_req),
    .i_dbg_wen  (i_dbg_wen),
    .i_dbg_addr (i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata),
    .i_dbg_lock (i_dbg_lock),
    .o_dbg_gnt  (o_dbg_gnt),
    .o_dbg_rdata(o_dbg_rdata),
    .o_mem_addr (o_mem_addr),
    .o_mem_wen  (o_mem_wen),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
    .o_state    (o_state)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 40503 + 7);
  endfunction

  // Memory/MMIO stand-in: asynchronous read, write on the clock edge.
  assign i_mem_rdata = mem[o_mem_addr[8:1]];
  always @(posedge i_clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (o_mem_wen) begin
      mem[o_mem_addr[8:1]] <= o_mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who has priority, how long the CPU has been waiting,
  // and what memory holds. Checked on every falling edge.
  int m_state = 0;   // 0 CPU priority, 1 debug priority, 2 debug lock
  int m_wait  = 0;
  int deny_run = 0;

  always @(negedge i_clk) begin
    bit            forced, ec, ed, dbg_first;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          ewen;
    int            nrun;

    forced = 1'b0; ec = 1'b0; ed = 1'b0;
    if (!i_rst) begin
      forced    = i_cpu_req && (m_wait == MAX_WAIT);
      dbg_first = (m_state != 0);
      if (forced)          ec = 1'b1;
      else if (dbg_first) begin ed = i_dbg_req; ec = i_cpu_req && !i_dbg_req; end
      else                begin ec = i_cpu_req; ed = i_dbg_req && !i_cpu_req; end
    end
    ea   = ec ? i_cpu_addr  : (ed ? i_dbg_addr  : '0);
    ew   = ec ? i_cpu_wdata : (ed ? i_dbg_wdata : '0);
    ewen = ec ? i_cpu_wen   : (ed ? i_dbg_wen   : 1'b0);

    if (init_mem) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= pat(i);
    end else begin
      chk("cpu_gnt",    32'(o_cpu_gnt),   32'(ec));
      chk("dbg_gnt",    32'(o_dbg_gnt),   32'(ed));
      chk("gnt_onehot", 32'(o_cpu_gnt & o_dbg_gnt), 32'd0);
      chk("cpu_stall",  32'(o_cpu_stall), 32'(i_cpu_req && !ec));
      chk("mem_wen",    32'(o_mem_wen),   32'(ewen));
      chk("mem_addr",   32'(o_mem_addr),  32'(ea));
      chk("mem_wdata",  32'(o_mem_wdata), 32'(ew));
      chk("state",      32'(o_state),     32'(m_state));
      if (ec && !i_cpu_wen) chk("cpu_rdata", 32'(o_cpu_rdata), 32'(ref_mem[i_cpu_addr[8:1]]));
      if (ed && !i_dbg_wen) chk("dbg_rdata", 32'(o_dbg_rdata), 32'(ref_mem[i_dbg_addr[8:1]]));
      nrun = (!i_rst && i_cpu_req && !o_cpu_gnt) ? deny_run + 1 : 0;
      chk("cpu_wait_bound", 32'(nrun <= MAX_WAIT), 32'd1);
      deny_run <= nrun;
      if (ewen) ref_mem[ea[8:1]] <= ew;
    end

    if (i_rst) begin
      m_state <= 0;
      m_wait  <= 0;
    end else begin
      if (ed)      m_state <= i_dbg_lock ? 2 : 0;
      else if (ec) m_state <= (forced && m_state == 2 && i_dbg_lock) ? 2 : (i_dbg_req ? 1 : 0);
      else         m_state <= (m_state == 2 && i_dbg_lock) ? 2 : 0;
      m_wait <= (i_cpu_req && !ec) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_cpu_req = req; i_cpu_wen = wen; i_cpu_addr = a; i_cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic wen, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lock);
    i_dbg_req = req; i_dbg_wen = wen; i_dbg_addr = a; i_dbg_wdata = d; i_dbg_lock = lock;
  endtask

  int gcount, g_first, g_second;

  initial begin
    init_mem = 1'b1;
    i_rst    = 1'b1;
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0, 0);
    repeat (2) @(posedge i_clk);
    #1 init_mem = 1'b0;
    @(negedge i_clk);
    chk("rst_cpu_gnt", 32'(o_cpu_gnt), 32'd0);
    chk("rst_state",   32'(o_state),   32'd0);
    tick();
    i_rst = 1'b0;

    // CPU-only store then load back.
    set_cpu(1, 1, 16'h0010, 16'hBEEF);
    @(negedge i_clk);
    chk("d_cpu_wr_gnt",  32'(o_cpu_gnt),   32'd1);
    chk("d_cpu_wr_wen",  32'(o_mem_wen),   32'd1);
    chk("d_cpu_wr_addr", 32'(o_mem_addr),  32'h0010);
    chk("d_cpu_wr_data", 32'(o_mem_wdata), 32'hBEEF);
    tick();
    set_cpu(1, 0, 16'h0010, 16'h0000);
    @(negedge i_clk);
    chk("d_cpu_rd_data", 32'(o_cpu_rdata), 32'hBEEF);
    tick();

    // Contention straight out of reset.
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    set_cpu(1, 0, 16'h0010, 16'h0000);
    set_dbg(1, 0, 16'h0020, 16'h0000, 0);
    @(negedge i_clk);
    chk("d_cont1_cpu_gnt", 32'(o_cpu_gnt),   32'd1);
    chk("d_cont1_stall",   32'(o_cpu_stall), 32'd0);
    tick();
    @(negedge i_clk);
    chk("d_cont2_dbg_gnt", 32'(o_dbg_gnt),   32'd1);
    chk("d_cont2_stall",   32'(o_cpu_stall), 32'd1);
    chk("d_cont2_state",   32'(o_state),     32'd1);
    tick();
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0, 0);
    tick();

    // Locked debug burst with the CPU requesting throughout.
    set_dbg(1, 0, 16'h0020, 16'h0000, 1);
    @(negedge i_clk);
    chk("d_lock_open", 32'(o_dbg_gnt), 32'd1);
    tick();
    set_cpu(1, 0, 16'h0010, 16'h0000);
    gcount = 0; g_first = 0; g_second = 0;
    for (int k = 1; k <= 20; k++) begin
      set_dbg(1, 1, AW'(16'h0040 + 2 * k), DW'(k), 1);
      @(negedge i_clk);
      if (o_cpu_gnt) begin
        gcount++;
        if (gcount == 1) g_first = k;
        if (gcount == 2) g_second = k;
      end
      tick();
    end
    chk("d_burst_count",  32'(gcount),   32'd2);
    chk("d_burst_first",  32'(g_first),  32'd9);
    chk("d_burst_second", 32'(g_second), 32'd18);

    // Debug write to the LED register while the CPU is also asking.
    set_dbg(1, 1, 16'h007A, 16'h003F, 1);
    @(negedge i_clk);
    chk("d_led_gnt",   32'(o_dbg_gnt),   32'd1);
    chk("d_led_wen",   32'(o_mem_wen),   32'd1);
    chk("d_led_addr",  32'(o_mem_addr),  32'h007A);
    chk("d_led_data",  32'(o_mem_wdata), 32'h003F);
    chk("d_led_stall", 32'(o_cpu_stall), 32'd1);
    tick();

    // Reset in the middle of a locked burst.
    set_dbg(1, 1, 16'h0030, 16'h1234, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("d_rst_cpu_gnt", 32'(o_cpu_gnt), 32'd0);
    chk("d_rst_dbg_gnt", 32'(o_dbg_gnt), 32'd0);
    chk("d_rst_wen",     32'(o_mem_wen), 32'd0);
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("d_post_rst_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
    chk("d_post_rst_state",   32'(o_state),   32'd0);
    tick();

    // Random two-master traffic.
    for (int n = 0; n < 3000; n++) begin
      i_rst = ($urandom_range(0, 299) == 0);
      set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              {11'd0, 4'($urandom), 1'b0}, DW'($urandom));
      if ($urandom_range(0, 7) == 0) i_dbg_lock = ~i_dbg_lock;
      set_dbg($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              {11'd0, 4'($urandom), 1'b0}, DW'($urandom), i_dbg_lock);
      tick();
    end
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
